// File: rtl/axis_upsizer.sv
`default_nettype none
// ============================================================================
// Module   : axis_upsizer
// Brief    : Packs RATIO narrow AXI-Stream beats into one registered wide beat.
//            Optional packet boundaries: define AXIS_UPSIZER_TLAST_EN.
// Revision : 1.0 - initial release
// ============================================================================
module axis_upsizer #(
    parameter int DATA_W = 32,
    parameter int RATIO  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [RATIO*DATA_W-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready
`ifdef AXIS_UPSIZER_TLAST_EN
    ,
    input  logic                    s_axis_tlast,
    output logic                    m_axis_tlast,
    output logic [RATIO-1:0]        m_axis_tkeep
`endif
);

    localparam int               CNT_W  = $clog2(RATIO);
    localparam int               BUF_W  = (RATIO-1)*DATA_W;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(RATIO-1);

    logic [CNT_W-1:0]        r_cnt;
    logic [BUF_W-1:0]        r_buf;
    logic                    w_final;
    logic                    w_in_xfer;
    logic [RATIO*DATA_W-1:0] w_word;

`ifdef AXIS_UPSIZER_TLAST_EN
    logic [RATIO*DATA_W-1:0] w_full;
    logic [RATIO-1:0]        w_keep;

    assign w_final = (r_cnt == C_LAST) || s_axis_tlast;
    assign w_full  = {s_axis_tdata, r_buf};

    // A short packet keeps lanes 0..cnt and zeroes the rest so stale
    // buffer contents from an earlier packet never leak out.
    always_comb begin
        w_word = '0;
        w_keep = '0;
        for (int j = 0; j < RATIO; j++) begin
            if (j == int'(r_cnt)) begin
                w_word[j*DATA_W +: DATA_W] = s_axis_tdata;
                w_keep[j]                  = 1'b1;
            end else if (j < int'(r_cnt)) begin
                w_word[j*DATA_W +: DATA_W] = w_full[j*DATA_W +: DATA_W];
                w_keep[j]                  = 1'b1;
            end
        end
    end
`else
    assign w_final = (r_cnt == C_LAST);
    assign w_word  = {s_axis_tdata, r_buf};
`endif

    // Only the word-completing beat has to wait for the output register.
    assign s_axis_tready = !w_final || !m_axis_tvalid || m_axis_tready;
    assign w_in_xfer     = s_axis_tvalid && s_axis_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= '0;
            m_axis_tvalid <= 1'b0;
        end else begin
            if (w_in_xfer) begin
                r_cnt <= w_final ? '0 : r_cnt + CNT_W'(1);
            end
            if (w_in_xfer && w_final) begin
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_xfer) begin
            for (int i = 0; i < RATIO-1; i++) begin
                if (int'(r_cnt) == i) begin
                    r_buf[i*DATA_W +: DATA_W] <= s_axis_tdata;
                end
            end
            if (w_final) begin
                m_axis_tdata <= w_word;
`ifdef AXIS_UPSIZER_TLAST_EN
                m_axis_tkeep <= w_keep;
                m_axis_tlast <= s_axis_tlast;
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_upsizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_upsizer
// Brief    : Self-checking bench for axis_upsizer (DATA_W=8, RATIO=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_upsizer;

    localparam int DATA_W = 8;
    localparam int RATIO  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  sd  = 8'h00;
    logic        sv  = 1'b0;
    logic        sr;
    logic [31:0] md;
    logic        mv;
    logic        mr  = 1'b1;
`ifdef AXIS_UPSIZER_TLAST_EN
    logic        s_tlast = 1'b0;
    logic        m_tlast;
    logic [3:0]  m_keep;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    axis_upsizer #(.DATA_W(DATA_W), .RATIO(RATIO)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (sd),
        .s_axis_tvalid (sv),
        .s_axis_tready (sr),
        .m_axis_tdata  (md),
        .m_axis_tvalid (mv),
        .m_axis_tready (mr)
`ifdef AXIS_UPSIZER_TLAST_EN
        ,
        .s_axis_tlast  (s_tlast),
        .m_axis_tlast  (m_tlast),
        .m_axis_tkeep  (m_keep)
`endif
    );

    typedef struct {
        logic        sv;
        logic [7:0]  sd;
        logic        mr;
        logic        exp_sr;
        logic        exp_mv;
        logic [31:0] exp_md;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        sv  = 1'b0;
        mr  = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [7:0]  part[$];
    logic [31:0] expq[$];

    initial begin
        int          nacc;
        int          cycles;
        logic        prev_stall;
        logic        pend;
        logic [31:0] prev_md;
        logic        exp_mv;

        // Stall sequence: the word sits held while the buffer refills behind it.
        tbl[0]  = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 32'h0};
        tbl[3]  = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 32'h0};
        tbl[4]  = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 32'h44332211};
        tbl[5]  = '{1'b1, 8'h66, 1'b0, 1'b1, 1'b1, 32'h44332211};
        tbl[6]  = '{1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 32'h44332211};
        tbl[7]  = '{1'b1, 8'h88, 1'b0, 1'b0, 1'b1, 32'h44332211};
        tbl[8]  = '{1'b1, 8'h88, 1'b1, 1'b1, 1'b1, 32'h44332211};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 32'h88776655};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'h88776655};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0};

        apply_reset();
        @(negedge clk);
        check("reset_m_valid", 32'(mv), 32'd0);
        check("reset_s_ready", 32'(sr), 32'd1);
        tick();

        for (int i = 0; i < 12; i++) begin
            sv = tbl[i].sv;
            sd = tbl[i].sd;
            mr = tbl[i].mr;
            @(negedge clk);
            check($sformatf("tbl%0d_s_ready", i), 32'(sr), 32'(tbl[i].exp_sr));
            check($sformatf("tbl%0d_m_valid", i), 32'(mv), 32'(tbl[i].exp_mv));
            if (tbl[i].exp_mv) check($sformatf("tbl%0d_m_data", i), md, tbl[i].exp_md);
            tick();
        end

        // Continuous stream 0x00..0x0F at full rate.
        apply_reset();
        for (int c = 0; c < 18; c++) begin
            sv = (c < 16);
            sd = 8'(c);
            mr = 1'b1;
            @(negedge clk);
            if (c < 16) check("stream_s_ready", 32'(sr), 32'd1);
            exp_mv = (c >= 4) && (c <= 16) && (c % 4 == 0);
            check($sformatf("stream_m_valid_c%0d", c), 32'(mv), 32'(exp_mv));
            if (exp_mv) check("stream_m_data", md, {8'(c-1), 8'(c-2), 8'(c-3), 8'(c-4)});
            tick();
        end

        // Reset mid-word drops the partial beats.
        apply_reset();
        sv = 1'b1; sd = 8'hAA; tick();
        sd = 8'hBB; tick();
        sv = 1'b0; rst = 1'b1; tick();
        rst = 1'b0;
        @(negedge clk);
        check("midreset_m_valid", 32'(mv), 32'd0);
        check("midreset_s_ready", 32'(sr), 32'd1);
        tick();
        for (int k = 0; k < 6; k++) begin
            sv = (k < 4);
            sd = 8'(k + 1);
            @(negedge clk);
            check($sformatf("midreset_m_valid_k%0d", k), 32'(mv), 32'(k == 4));
            if (k == 4) check("midreset_m_data", md, 32'h04030201);
            tick();
        end

`ifdef AXIS_UPSIZER_TLAST_EN
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            sv      = (k < 6);
            sd      = (k == 0) ? 8'h55 : (k == 1) ? 8'h66 : 8'(k - 1);
            s_tlast = (k == 1);
            @(negedge clk);
            check($sformatf("tlast_m_valid_k%0d", k), 32'(mv), 32'((k == 2) || (k == 6)));
            if (k == 2) begin
                check("tlast_short_data", md, 32'h00006655);
                check("tlast_short_keep", 32'(m_keep), 32'h3);
                check("tlast_short_last", 32'(m_tlast), 32'd1);
            end
            if (k == 6) begin
                check("tlast_full_data", md, 32'h04030201);
                check("tlast_full_keep", 32'(m_keep), 32'hF);
                check("tlast_full_last", 32'(m_tlast), 32'd0);
            end
            tick();
        end
        s_tlast = 1'b0;
`endif

        // Randomised traffic against a queue-based packing model.
        apply_reset();
        part.delete();
        expq.delete();
        nacc       = 0;
        cycles     = 0;
        prev_stall = 1'b0;
        pend       = 1'b0;
        prev_md    = 32'h0;
        while (!(nacc >= 10000 && expq.size() == 0 && !mv) && cycles < 60000) begin
            sv = (nacc < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
            sd = 8'($urandom);
            mr = 1'($urandom_range(0, 1));
            @(negedge clk);
            cycles++;
            check("rand_s_ready", 32'(sr), 32'((part.size() != RATIO-1) || !mv || mr));
            if (prev_stall) begin
                check("rand_hold_valid", 32'(mv), 32'd1);
                check("rand_hold_data", md, prev_md);
            end
            if (pend) check("rand_latency", 32'(mv), 32'd1);
            if (mv && mr) begin
                if (expq.size() == 0) check("rand_spurious_valid", 32'(mv), 32'd0);
                else                  check("rand_word", md, expq.pop_front());
            end
            pend = 1'b0;
            if (sv && sr) begin
                part.push_back(sd);
                nacc++;
                if (part.size() == RATIO) begin
                    expq.push_back({part[3], part[2], part[1], part[0]});
                    part.delete();
                    pend = 1'b1;
                end
            end
            prev_stall = mv && !mr;
            prev_md    = md;
            tick();
        end
        if (cycles >= 60000) check("rand_timeout_cycles", 32'(cycles), 32'd0);
        check("rand_drained", 32'(expq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axis_upsizer.md
Name: axis_upsizer

Overview:
- Packs RATIO consecutive narrow AXI-Stream beats into one wide beat of RATIO*DATA_W bits.
- Sits directly upstream of the pipeline register stage and feeds its slave port.
- Output is registered.
- Sustains one input beat per cycle when downstream is ready.

Parameters:
- DATA_W, 32: input beat width in bits.
- RATIO, 4: input beats per output beat; legal range 2..64, need not be a power of two.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- s_axis_tdata  input  DATA_W  narrow input data.
- s_axis_tvalid  input  1  input valid.
- s_axis_tready  output  1  input ready.
- m_axis_tdata  output  RATIO*DATA_W  packed output data.
- m_axis_tvalid  output  1  output valid.
- m_axis_tready  input  1  output ready.
- s_axis_tlast  input  1  end of packet; present only with the optional feature.
- m_axis_tlast  output  1  end of packet; present only with the optional feature.
- m_axis_tkeep  output  RATIO  per-lane valid mask; present only with the optional feature.

Behaviour:
- Transfers: input transfer = s_axis_tvalid && s_axis_tready. Output transfer = m_axis_tvalid && m_axis_tready.
- State:
  - lane counter cnt, width $clog2(RATIO), range 0..RATIO-1.
  - accumulation buffer of (RATIO-1)*DATA_W bits.
  - output register (data, valid).
- Reset (rst=1 at a clock edge):
  - cnt=0, m_axis_tvalid=0, buffer contents discarded.
  - Output tdata, and tkeep/tlast under the feature, are not reset; they are don't-care while valid=0.
  - Reset mid-packet drops all partially packed beats. No output beat is emitted for them.
- Packing order: little-endian.
  - First accepted beat goes to lane 0, bits [DATA_W-1:0].
  - Beat k goes to lane k, bits [(k+1)*DATA_W-1 : k*DATA_W].
- Input transfer with cnt < RATIO-1:
  - Beat written to buffer lane cnt.
  - cnt increments by 1.
  - Output register untouched.
- Input transfer with cnt == RATIO-1 (final beat):
  - Output register loads {s_axis_tdata, buffer}.
  - m_axis_tvalid=1 on the next cycle.
  - cnt wraps to 0.
- Latency: m_axis_tvalid rises exactly 1 cycle after the final input beat is accepted.
- Output transfer without a simultaneous final-beat load: m_axis_tvalid clears to 0 on the next cycle.
- Simultaneous output transfer and final-beat load: the new word replaces the old and m_axis_tvalid stays 1. No bubble, no loss.
- s_axis_tready = (cnt != RATIO-1) || !m_axis_tvalid || m_axis_tready.
  - Non-final beats are accepted even while the output stalls, so the buffer fills behind the stalled word.
  - Only the final beat waits for the output register to free.
  - The combinational path from m_axis_tready to s_axis_tready is allowed only on the final beat. The downstream register stage breaks it.
- Output stability: while m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata (and tkeep/tlast) hold stable.
- Input ordering: s_axis_tdata is sampled only on an input transfer. Data offered while tready=0 is ignored; no reordering, no duplication.

Optional Feature:
- Macro: AXIS_UPSIZER_TLAST_EN.
- Defined:
  - Adds s_axis_tlast, m_axis_tlast and m_axis_tkeep.
  - Input transfer with s_axis_tlast=1 at cnt=c forces the final-beat path: the output word loads at once and cnt returns to 0.
  - Lanes 0..c hold data. Lanes c+1..RATIO-1 are zero.
  - m_axis_tkeep has bits 0..c set; m_axis_tlast=1.
  - Final-beat readiness applies: s_axis_tready with s_axis_tlast=1 follows the cnt==RATIO-1 rule regardless of cnt.
  - A full word without tlast gives tkeep all ones and tlast=0.
  - A full word whose last beat has tlast gives tkeep all ones and tlast=1.
- Undefined:
  - Ports absent; a word is emitted only after RATIO beats.

Test Plan (DATA_W=8, RATIO=4):
- Reset, then beats 0x11,0x22,0x33,0x44 on consecutive cycles with m_axis_tready=1 -> one cycle after 0x44 is accepted, m_axis_tvalid=1 and m_axis_tdata=0x44332211 for exactly 1 cycle.
- Continuous stream 0x00..0x0F, tvalid and tready always 1 -> s_axis_tready stays 1 throughout; 4 output words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C on cycles 4 apart, no gaps.
- m_axis_tready=0 after the first word -> 3 more beats accepted, then s_axis_tready=0 at cnt=3 with m_axis_tdata held; raise m_axis_tready -> final beat accepted in the same cycle and the next word valid the following cycle.
- Assert rst after 2 beats (0xAA,0xBB), then send 0x01..0x04 -> only 0x04030201 is output; 0xAA/0xBB never appear.
- With AXIS_UPSIZER_TLAST_EN: beats 0x55,0x66 with tlast on 0x66 -> m_axis_tdata=0x00006655, m_axis_tkeep=4'b0011, m_axis_tlast=1; the next 4 beats give tkeep=4'b1111.
- Random tvalid/tready (50%) for 10000 beats -> output word sequence matches a scoreboard packing model exactly; tdata stable whenever tvalid=1 && tready=0.
